shift_tx_sequencer: RTL
=======================

// Module: shift_tx_sequencer
// PURPOSE
//  Controller that sequences an internal WIDTH-bit shift register to serialise words.
//  A valid/ready handshake loads one parallel word. The controller shifts it out one
//  bit per CLKS_PER_BIT clocks, then inserts GAP_BITS idle bit-times and pulses done.
//  It sits between a word producer (FIFO/CPU reg) and a serial pin or downstream sampler.
// PARAMETERS
//  WIDTH         8  bits per word (>=2)
//  CLKS_PER_BIT  4  clocks each bit is held on sdo (>=1)
//  GAP_BITS      1  idle bit-times after last bit before done/ready (>=0)
//  MSB_FIRST     1  1: shift left, sdo=sreg[WIDTH-1]; 0: shift right, sdo=sreg[0]
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_data    in   WIDTH  parallel word, sampled only on accept
//  in_valid   in   1      producer has a word
//  in_ready   out  1      controller can accept (comb: state==IDLE && !abort)
//  abort      in   1      synchronous cancel of current word
//  sdo        out  1      serial data out
//  sdo_valid  out  1      1-cycle strobe, first clock of each bit period
//  busy       out  1      state!=IDLE
//  done       out  1      1-cycle pulse, last cycle of a completed word
// BEHAVIOUR
//  Reset (async, any time incl. mid-word): state=IDLE, sreg=0, bit_cnt=0, div_cnt=0.
//   After reset: sdo=0, sdo_valid=0, busy=0, done=0, in_ready=1 once rst deasserts.
//  States: IDLE -> SHIFT -> (GAP if GAP_BITS>0) -> IDLE.
//  IDLE: sdo=0. Accept = in_valid && in_ready.
//   On accept: sreg<=in_data, bit_cnt<=0, div_cnt<=0, state<=SHIFT.
//  SHIFT: sdo = MSB_FIRST ? sreg[WIDTH-1] : sreg[0]; sdo_valid = (div_cnt==0).
//   div_cnt counts 0..CLKS_PER_BIT-1. At div_cnt==CLKS_PER_BIT-1:
//   - bit_cnt<WIDTH-1: shift sreg by exactly 1 toward the output end, zero fill.
//     Also bit_cnt++, div_cnt<=0.
//   - bit_cnt==WIDTH-1 and GAP_BITS>0: state<=GAP, div_cnt<=0.
//   - bit_cnt==WIDTH-1 and GAP_BITS==0: done=1 this cycle, state<=IDLE.
//  GAP: sdo=0, sdo_valid=0. Counter runs GAP_BITS*CLKS_PER_BIT cycles.
//   done=1 on the final GAP cycle, then state<=IDLE.
//  Latency: accept at cycle T -> first bit on sdo at T+1.
//   done at T + (WIDTH+GAP_BITS)*CLKS_PER_BIT; in_ready at T + that + 1.
//   Word period (back-to-back) = 1 + (WIDTH+GAP_BITS)*CLKS_PER_BIT cycles.
//  in_data/in_valid are ignored while busy. No accept is possible in the done cycle.
//  abort (any state): next state IDLE, sreg/counters cleared, no done pulse.
//   abort with in_valid in IDLE: no accept (abort wins).
//  Counters are sized for their max value. div_cnt wraps only via the explicit reset
//   to 0 above, never by overflow.
// TESTING
//  1. Assert/release rst -> sdo=0, busy=0, done=0, sdo_valid=0, in_ready=1.
//  2. Defaults; send 0xA5 at T -> sdo=1,0,1,0,0,1,0,1, each held 4 clks from T+1.
//     sdo_valid at T+1,T+5,...,T+29; sdo=0 T+33..T+36; done at T+36; in_ready T+37.
//  3. MSB_FIRST=0, CLKS_PER_BIT=1, GAP_BITS=0; send 0x01 at T.
//     -> sdo=1 at T+1, then 0 for T+2..T+8; done at T+8; in_ready at T+9.
//  4. Defaults, in_valid held high with 0x3C then 0xC3; in_data toggled during shift.
//     -> second accept exactly at T+37; first word's bits unaffected by toggling.
//  5. Defaults; abort during 4th bit -> next cycle IDLE, sdo=0, busy=0, no done.
//     A following word is serialised correctly.
//  6. Async rst pulse mid-SHIFT (between clock edges) -> outputs 0 immediately.
//     After release, 0xFF is sent correctly with standard latency.

Source files
------------

// File: rtl/shift_tx_sequencer.sv
// shift_tx_sequencer
// Loads one parallel word through a valid/ready handshake and shifts it out on sdo.
// Each bit is held for CLKS_PER_BIT clocks. An optional idle gap of GAP_BITS bit-times
// follows the last bit, and done pulses on the final cycle of the word.
// abort cancels the current word at the next edge, and no done pulse is produced.

module shift_tx_sequencer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_BITS     = 1,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             busy,
    output logic             done
);

    // Each counter is sized for its largest value. A counter is at least 1 bit wide
    // when its range collapses to a single value.
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W    = $clog2(WIDTH);
    localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    // State register and datapath flops; asynchronous reset returns everything to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic, handshake, bit timing and the serial outputs.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sdo       = 1'b0;
        sdo_valid = 1'b0;
        done      = 1'b0;
        in_ready  = (state_q == S_IDLE) && !abort;
        busy      = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    sreg_d    = in_data;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                sdo       = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
                sdo_valid = (div_cnt_q == '0);
                if (div_cnt_q == DIV_LAST) begin
                    if (bit_cnt_q != BIT_LAST) begin
                        // Move the next bit into the output position and fill with zero.
                        sreg_d    = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                              : {1'b0, sreg_q[WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        div_cnt_d = '0;
                    end else if (GAP_BITS > 0) begin
                        state_d   = S_GAP;
                        div_cnt_d = '0;
                        gap_cnt_d = '0;
                    end else begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // abort overrides everything, including a done pulse that would occur this cycle.
        if (abort) begin
            state_d   = S_IDLE;
            sreg_d    = '0;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            gap_cnt_d = '0;
            done      = 1'b0;
        end
    end

endmodule
